// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator and pixel output stage (optional VGA_TEST_PATTERN_EN colour-bar source)
module vga_timing_gen #(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   X_W      = 10,
    parameter int   Y_W      = 10
) (
    input  logic           clk_50MHz,
    input  logic           vga_reset,
    input  logic [7:0]     color_in,
    input  logic           pattern_sel,
    output logic [X_W-1:0] next_x,
    output logic [Y_W-1:0] next_y,
    output logic           hsync,
    output logic           vsync,
    output logic [7:0]     red,
    output logic [7:0]     green,
    output logic [7:0]     blue,
    output logic           blank,
    output logic           sync,
    output logic           clk,
    output logic           frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int D_CW     = $clog2(CLK_DIV);
    localparam int H_CW     = $clog2(H_TOTAL);
    localparam int V_CW     = $clog2(V_TOTAL);

    logic [D_CW-1:0] div_cnt;
    logic [D_CW-1:0] div_next;
    logic [H_CW-1:0] h_cnt;
    logic [V_CW-1:0] v_cnt;
    logic            pix_en;
    logic            h_last;
    logic            v_last;
    logic            h_vis;
    logic            v_vis;
    logic            visible;
    logic            in_hs;
    logic            in_vs;
    logic [7:0]      pix_color;

    // Pixel-rate enable: one system clock in every CLK_DIV
    assign pix_en   = (int'(div_cnt) == CLK_DIV - 1);
    assign div_next = pix_en ? '0 : div_cnt + 1'b1;

    assign h_last  = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last  = (int'(v_cnt) == V_TOTAL - 1);
    assign h_vis   = (int'(h_cnt) < H_ACTIVE);
    assign v_vis   = (int'(v_cnt) < V_ACTIVE);
    assign visible = h_vis && v_vis;
    assign in_hs   = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    assign in_vs   = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);

    assign next_x = h_vis ? X_W'(h_cnt) : '0;
    assign next_y = v_vis ? Y_W'(v_cnt) : '0;

    // Composite sync is not used by this board
    assign sync = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;

    // Bar index = floor(h_cnt*8/H_ACTIVE), as a count of thresholds crossed
    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if ({h_cnt, 3'b000} >= (H_CW+3)'(i * H_ACTIVE)) begin
                bar = bar + 3'd1;
            end
        end
    end

    // Colour source: internal bars when selected, otherwise external colour
    always_comb begin
        pix_color = color_in;
        if (pattern_sel) begin
            case (bar)
                3'd0:    pix_color = 8'hFF;
                3'd1:    pix_color = 8'hFC;
                3'd2:    pix_color = 8'h1F;
                3'd3:    pix_color = 8'h1C;
                3'd4:    pix_color = 8'hE3;
                3'd5:    pix_color = 8'hE0;
                3'd6:    pix_color = 8'h03;
                default: pix_color = 8'h00;
            endcase
        end
    end
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign pix_color          = color_in;
`endif

    // Divider and DAC pixel clock; clk follows the divider phase so data changes while it is low
    always_ff @(posedge clk_50MHz or posedge vga_reset) begin
        if (vga_reset) begin
            div_cnt <= '0;
            clk     <= 1'b0;
        end else begin
            div_cnt <= div_next;
            clk     <= (int'(div_next) >= CLK_DIV / 2);
        end
    end

    // Horizontal and vertical position counters, advanced once per pixel
    always_ff @(posedge clk_50MHz or posedge vga_reset) begin
        if (vga_reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Registered pixel outputs for the current position, updated on each pixel enable
    always_ff @(posedge clk_50MHz or posedge vga_reset) begin
        if (vga_reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            blank       <= 1'b0;
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                hsync       <= in_hs ? SYNC_POL : ~SYNC_POL;
                vsync       <= in_vs ? SYNC_POL : ~SYNC_POL;
                blank       <= visible;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                if (visible) begin
                    red   <= {pix_color[7:5], pix_color[7:5], pix_color[7:6]};
                    green <= {pix_color[4:2], pix_color[4:2], pix_color[4:3]};
                    blue  <= {pix_color[1:0], pix_color[1:0], pix_color[1:0], pix_color[1:0]};
                end else begin
                    red   <= 8'h00;
                    green <= 8'h00;
                    blue  <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] c;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    typedef struct {
        int         x;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pvec_t;

    logic clk_50MHz = 1'b0;
    logic rst;

    logic [7:0] color_a;
    logic       pat_a;
    logic [9:0] next_x_a;
    logic [9:0] next_y_a;
    logic       hsync_a, vsync_a, blank_a, sync_a, clk_a, fs_a;
    logic [7:0] red_a, green_a, blue_a;

    logic [7:0] color_b;
    logic       pat_b;
    logic [4:0] next_x_b;
    logic [3:0] next_y_b;
    logic       hsync_b, vsync_b, blank_b, sync_b, clk_b, fs_b;
    logic [7:0] red_b, green_b, blue_b;

    int    n_checks = 0;
    int    n_fail   = 0;
    vec_t  vecs [7];
    pvec_t pvecs [3];

    always #10 clk_50MHz = ~clk_50MHz;

    vga_timing_gen dut_a (
        .clk_50MHz   (clk_50MHz),
        .vga_reset   (rst),
        .color_in    (color_a),
        .pattern_sel (pat_a),
        .next_x      (next_x_a),
        .next_y      (next_y_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .red         (red_a),
        .green       (green_a),
        .blue        (blue_a),
        .blank       (blank_a),
        .sync        (sync_a),
        .clk         (clk_a),
        .frame_start (fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV (3), .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (8), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b1), .X_W (5), .Y_W (4)
    ) dut_b (
        .clk_50MHz   (clk_50MHz),
        .vga_reset   (rst),
        .color_in    (color_b),
        .pattern_sel (pat_b),
        .next_x      (next_x_b),
        .next_y      (next_y_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .red         (red_b),
        .green       (green_b),
        .blue        (blue_b),
        .blank       (blank_b),
        .sync        (sync_b),
        .clk         (clk_b),
        .frame_start (fs_b)
    );

    // Colour source for dut_a: table colour at the listed pixels, FF everywhere else
    always_comb begin
        color_a = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            if (int'(next_x_a) == vecs[i].x && int'(next_y_a) == vecs[i].y) begin
                color_a = vecs[i].c;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait until dut_a is showing pixel (x,y): the cycle after that pixel was registered
    task automatic wait_pix_a(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40000 && !ok; k++) begin
            @(negedge clk_50MHz);
            if (int'(next_x_a) == x + 1 && int'(next_y_a) == y) ok = 1'b1;
        end
    endtask

    task automatic wait_pix_b(input int x, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk_50MHz);
            if (int'(next_x_b) == x + 1 && blank_b) ok = 1'b1;
        end
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit prev_ha;
        bit prev_vb;
        bit prev_hb;
        int fall1, rise1, fall2, blank_cnt;
        int vrise1, vfall1, vrise2, hrise_b;
        int fs_cnt, fs_last, fs_prev;

        vecs[0] = '{x: 5,   y: 7, c: 8'hE3, r: 8'hFF, g: 8'h00, b: 8'hFF};
        vecs[1] = '{x: 10,  y: 7, c: 8'h49, r: 8'h49, g: 8'h49, b: 8'h55};
        vecs[2] = '{x: 20,  y: 7, c: 8'h00, r: 8'h00, g: 8'h00, b: 8'h00};
        vecs[3] = '{x: 30,  y: 8, c: 8'hFF, r: 8'hFF, g: 8'hFF, b: 8'hFF};
        vecs[4] = '{x: 3,   y: 9, c: 8'h1C, r: 8'h00, g: 8'hFF, b: 8'h00};
        vecs[5] = '{x: 100, y: 9, c: 8'h03, r: 8'h00, g: 8'h00, b: 8'hFF};
        vecs[6] = '{x: 638, y: 9, c: 8'hA5, r: 8'hB6, g: 8'h24, b: 8'h55};
`ifdef VGA_TEST_PATTERN_EN
        pvecs[0] = '{x: 0,  r: 8'hFF, g: 8'hFF, b: 8'hFF};
        pvecs[1] = '{x: 2,  r: 8'hFF, g: 8'hFF, b: 8'h00};
        pvecs[2] = '{x: 14, r: 8'h00, g: 8'h00, b: 8'h00};
`else
        pvecs[0] = '{x: 0,  r: 8'h49, g: 8'h49, b: 8'h55};
        pvecs[1] = '{x: 2,  r: 8'h49, g: 8'h49, b: 8'h55};
        pvecs[2] = '{x: 14, r: 8'h49, g: 8'h49, b: 8'h55};
`endif

        rst     = 1'b1;
        pat_a   = 1'b0;
        pat_b   = 1'b0;
        color_b = 8'h49;
        repeat (5) @(negedge clk_50MHz);

        check("reset_hsync_a", hsync_a, 1);
        check("reset_vsync_a", vsync_a, 1);
        check("reset_blank_a", blank_a, 0);
        check("reset_rgb_a", {red_a, green_a, blue_a}, 0);
        check("reset_clk_sync_fs_a", {clk_a, sync_a, fs_a}, 0);
        check("reset_next_a", {next_x_a, next_y_a}, 0);
        check("reset_hsync_b", hsync_b, 0);
        check("reset_vsync_b", vsync_b, 0);

        rst = 1'b0;
        prev_ha = hsync_a;
        prev_vb = vsync_b;
        prev_hb = hsync_b;
        fall1 = -1; rise1 = -1; fall2 = -1; blank_cnt = 0;
        vrise1 = -1; vfall1 = -1; vrise2 = -1; hrise_b = -1;
        fs_cnt = 0; fs_last = -1; fs_prev = -1;

        // e counts rising edges since reset release
        for (int e = 1; e <= 3300; e++) begin
            @(negedge clk_50MHz);
            if (e == 1) check("fs_a_edge1", fs_a, 0);
            if (e == 2) begin
                check("fs_a_edge2", fs_a, 1);
                check("clk_a_edge2", clk_a, 0);
                check("next_x_a_edge2", next_x_a, 1);
            end
            if (e == 3) begin
                check("fs_a_edge3", fs_a, 0);
                check("clk_a_edge3", clk_a, 1);
            end
            if (e >= 2 && e <= 1601 && blank_a) blank_cnt++;
            if (prev_ha && !hsync_a) begin
                if (fall1 < 0) fall1 = e;
                else if (fall2 < 0) fall2 = e;
            end
            if (!prev_ha && hsync_a && rise1 < 0 && fall1 >= 0) rise1 = e;
            if (!prev_hb && hsync_b && hrise_b < 0) hrise_b = e;
            if (!prev_vb && vsync_b) begin
                if (vrise1 < 0) vrise1 = e;
                else if (vrise2 < 0) vrise2 = e;
            end
            if (prev_vb && !vsync_b && vfall1 < 0) vfall1 = e;
            if (fs_b) begin
                fs_cnt++;
                fs_prev = fs_last;
                fs_last = e;
            end
            prev_ha = hsync_a;
            prev_vb = vsync_b;
            prev_hb = hsync_b;
        end

        check("hsync_a_first_fall", fall1, 1314);
        check("hsync_a_low_width", rise1 - fall1, 192);
        check("hsync_a_period", fall2 - fall1, 1600);
        check("blank_a_high_per_line", blank_cnt, 1280);
        check("vsync_a_idle", vsync_a, 1);
        check("hsync_b_first_rise", hrise_b, 57);
        check("vsync_b_first_rise", vrise1, 723);
        check("vsync_b_high_width", vfall1 - vrise1, 144);
        check("vsync_b_period", vrise2 - vrise1, 1008);
        check("fs_b_count", fs_cnt, 4);
        check("fs_b_first", fs_last - 3 * 1008, 3);
        check("fs_b_period", fs_last - fs_prev, 1008);

        for (int i = 0; i < 7; i++) begin
            wait_pix_a(vecs[i].x, vecs[i].y, ok);
            check($sformatf("wait_pix_a_%0d", i), ok, 1);
            check($sformatf("red_a_%0d", i), red_a, vecs[i].r);
            check($sformatf("green_a_%0d", i), green_a, vecs[i].g);
            check($sformatf("blue_a_%0d", i), blue_a, vecs[i].b);
            check($sformatf("blank_a_%0d", i), blank_a, 1);
        end

        ok = 1'b0;
        for (int k = 0; k < 4000 && !ok; k++) begin
            @(negedge clk_50MHz);
            if (!hsync_a) ok = 1'b1;
        end
        check("wait_hsync_a", ok, 1);
        check("invisible_rgb_a", {red_a, green_a, blue_a}, 0);
        check("invisible_blank_a", blank_a, 0);

        pat_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_pix_b(pvecs[i].x, ok);
            check($sformatf("wait_pix_b_%0d", i), ok, 1);
            check($sformatf("pattern_rgb_b_%0d", i), {red_b, green_b, blue_b},
                  {pvecs[i].r, pvecs[i].g, pvecs[i].b});
        end
        pat_b = 1'b0;

        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk_50MHz);
            if (next_y_b == 4'd5 && next_x_b == 5'd7) ok = 1'b1;
        end
        check("wait_mid_frame_b", ok, 1);
        rst = 1'b1;
        #1;
        check("midreset_hsync_vsync_b", {hsync_b, vsync_b}, 0);
        check("midreset_blank_fs_clk_b", {blank_b, fs_b, clk_b}, 0);
        check("midreset_rgb_b", {red_b, green_b, blue_b}, 0);
        check("midreset_next_b", {next_x_b, next_y_b}, 0);
        check("midreset_next_a", {next_x_a, next_y_a}, 0);
        @(negedge clk_50MHz);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk_50MHz);
            check($sformatf("restart_fs_b_e%0d", e), fs_b, (e == 3) ? 1 : 0);
            if (e == 3) begin
                check("restart_next_b", {next_x_b, next_y_b}, {5'd1, 4'd0});
                check("restart_blank_b", blank_b, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
